inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
Parametrised instruction-fetch front end for the core. It owns the instruction memory and runs a LOAD phase, in which program words arrive over a valid/ready stream, followed by a RUN phase. In RUN it streams instructions with matching PCs to decode through a latency-aware fetch pipeline. The pipeline supports freeze-stall and a redirect that squashes in-flight fetches.

Parameters:
XLEN, 32, width of data, PC and instruction.
IMEM_DEPTH, 4096, instruction memory words; power of two, at least 2.
MEM_LATENCY, 2, RAM read latency in cycles; legal values are 1 and 2.
RESET_PC, 0, first fetch PC on entering RUN; word aligned.

Ports:
clk_100mhz  input  1  clock
rst_in  input  1  synchronous, active-low reset (0 = reset)
load_valid_in  input  1  program word valid
load_data_in  input  XLEN  program word
load_last_in  input  1  marks the final program word
load_ready_out  output  1  unit accepts load words
start_in  input  1  in LOAD: enter RUN without writing
load_count_out  output  $clog2(IMEM_DEPTH+1)  words written since reset
running_out  output  1  unit is in RUN
stall_in  input  1  downstream cannot accept; freezes pipeline
redirect_in  input  1  branch/jump redirect
redirect_pc_in  input  XLEN  redirect target
inst_valid_out  output  1  inst_out and pc_out are valid
inst_out  output  XLEN  fetched instruction
pc_out  output  XLEN  PC of inst_out

Behaviour:
- Reset (rst_in=0 at a clock edge):
  - state=LOAD; load_count_out=0; running_out=0; load_ready_out=0; inst_valid_out=0; inst_out=0; pc_out=0.
  - All in-flight valid bits are cleared. Memory contents are preserved.
  - Reset mid-RUN returns the unit to LOAD.
- State LOAD:
  - load_ready_out=1 from the first cycle after reset is released.
  - A beat is accepted when load_valid_in & load_ready_out. The word is written at address load_count_out, and the count increments.
  - Transition to RUN on the next edge if any of these hold: an accepted beat has load_last_in=1; start_in=1; or the count reaches IMEM_DEPTH.
  - If start_in=1 and a beat is accepted in the same cycle, the word is written and then RUN is entered.
  - stall_in and redirect_in are ignored in LOAD.
- State RUN:
  - load_ready_out=0; running_out=1. Fetch PC starts at RESET_PC.
  - RAM address = pc[$clog2(IMEM_DEPTH)+1:2]. This wraps modulo IMEM_DEPTH; pc itself increments at full XLEN.
- Fetch pipeline:
  - MEM_LATENCY stages, each carrying {valid, pc}. One fetch is issued per unstalled cycle, and next pc = pc+4.
  - The first inst_valid_out rises MEM_LATENCY cycles after the first RUN cycle. After that the unit delivers one instruction per cycle.
- Stall:
  - stall_in=1 freezes the issue PC, all stage registers and the RAM enable/output-register enable.
  - inst_out, pc_out and inst_valid_out hold. No instruction is lost or duplicated.
  - A transfer occurs when inst_valid_out & ~stall_in.
- Redirect:
  - redirect_in=1 in RUN clears every in-flight valid bit, including the output, on that edge.
  - Next issue PC = {redirect_pc_in[XLEN-1:2], 2'b00}.
  - A valid output at the target appears MEM_LATENCY cycles later, absent stalls.
  - Redirect has priority over a simultaneous stall_in.
  - A redirect while inst_valid_out=0 behaves identically.

Decomposition:
- Shared package (types.svh): fetch_state_t enum {FETCH_LOAD, FETCH_RUN}; word-offset constant 2.
- One sub-module: fetch_ram. It is a behavioural single-port, read-first RAM with parameters WIDTH, DEPTH and LATENCY, and an enable and output-register enable used for freeze.

Test Plan:
- Reset release, then load 0xA,0xB,0xC with last on 0xC (MEM_LATENCY=2). Required: load_count_out=3, running_out=1 next cycle, and pc_out 0,4,8 / inst_out 0xA,0xB,0xC valid on consecutive cycles starting 2 cycles into RUN.
- stall_in held 3 cycles while pc_out=4 is valid. Required: outputs held at 4/0xB; after release, pc 8/0xC follows with no gap or duplicate.
- redirect_in with redirect_pc_in=0x11 while pc 4 and 8 are in flight. Required: neither is ever valid; the next valid output is pc_out=0x10, 2 cycles later.
- redirect_in and stall_in asserted together. Required: flush occurs and the target is fetched; the stall does not preserve the old output.
- IMEM_DEPTH=8, load 8 words with no last. Required: auto-RUN at count 8; pc_out=0x20 returns word 0; MEM_LATENCY=1 variant gives first valid 1 cycle into RUN.
- Reset mid-RUN, then start_in=1 with load_valid_in held during reset. Required: no beat accepted during reset, RUN re-entered, original program replayed from pc 0.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package inst_fetch_unit_pkg;

   typedef enum logic {
      FETCH_LOAD = 1'b0,
      FETCH_RUN  = 1'b1
   } fetch_state_t;

   // Byte-to-word shift: instructions are 4-byte aligned.
   localparam int WORD_OFFSET = 2;

   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - load stream, control and instruction stream bundle of the fetch unit
interface inst_fetch_unit_if
   import inst_fetch_unit_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int IMEM_DEPTH = 4096
);
   localparam int CNT_W = count_width(IMEM_DEPTH);

   logic             load_valid_in;
   logic [XLEN-1:0]  load_data_in;
   logic             load_last_in;
   logic             load_ready_out;
   logic             start_in;
   logic [CNT_W-1:0] load_count_out;
   logic             running_out;
   logic             stall_in;
   logic             redirect_in;
   logic [XLEN-1:0]  redirect_pc_in;
   logic             inst_valid_out;
   logic [XLEN-1:0]  inst_out;
   logic [XLEN-1:0]  pc_out;

   modport master (
      output load_valid_in, load_data_in, load_last_in, start_in,
      output stall_in, redirect_in, redirect_pc_in,
      input  load_ready_out, load_count_out, running_out,
      input  inst_valid_out, inst_out, pc_out
   );

   modport slave (
      input  load_valid_in, load_data_in, load_last_in, start_in,
      input  stall_in, redirect_in, redirect_pc_in,
      output load_ready_out, load_count_out, running_out,
      output inst_valid_out, inst_out, pc_out
   );

endinterface

// File: rtl/inst_fetch_unit_fetch_ram.sv
// rtl/inst_fetch_unit_fetch_ram.sv - single-port read-first RAM with 1 or 2 cycle read latency
module fetch_ram #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 4096,
   parameter int LATENCY = 2
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     i_en,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_addr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_oreg_en,
   output logic [WIDTH-1:0]         o_rdata
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_q1;

   // The array has no reset so program contents survive a unit reset.
   always_ff @(posedge clk) begin
      if (i_en && i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_q1 <= '0;
      end else if (i_en) begin
         r_q1 <= r_mem[i_addr];
      end
   end

   generate
      if (LATENCY == 2) begin : g_oreg
         logic [WIDTH-1:0] r_q2;
         always_ff @(posedge clk) begin
            if (!rstn) begin
               r_q2 <= '0;
            end else if (i_oreg_en) begin
               r_q2 <= r_q1;
            end
         end
         assign o_rdata = r_q2;
      end else begin : g_no_oreg
         assign o_rdata = r_q1;
      end
   endgenerate

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch front end: program load phase, then pipelined fetch
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter int          XLEN        = 32,
   parameter int          IMEM_DEPTH  = 4096,
   parameter int          MEM_LATENCY = 2,
   parameter int unsigned RESET_PC    = 0
) (
   input  logic             clk_100mhz,
   input  logic             rst_in,
   inst_fetch_unit_if.slave bus
);
   localparam int              AW      = $clog2(IMEM_DEPTH);
   localparam int              CW      = count_width(IMEM_DEPTH);
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(1 << WORD_OFFSET);
   localparam logic [XLEN-1:0] PC_INIT = XLEN'(RESET_PC);
   localparam logic [CW-1:0]   CNT_MAX = CW'(IMEM_DEPTH);

   fetch_state_t              r_state;
   logic                      r_load_ready;
   logic [CW-1:0]             r_load_count;
   logic [XLEN-1:0]           r_pc;
   logic [MEM_LATENCY-1:0]    r_stg_vld;
   logic [XLEN-1:0]           r_stg_pc [MEM_LATENCY];

   logic                      w_run;
   logic                      w_accept;
   logic [CW-1:0]             w_count_nxt;
   logic                      w_load_done;
   logic                      w_issue;
   logic [XLEN-1:0]           w_issue_pc;
   logic [AW-1:0]             w_ram_addr;
   logic                      w_ram_en;
   logic                      w_ram_we;
   logic [XLEN-1:0]           w_rdata;
   logic                      w_unused_rpc;

   assign w_run       = (r_state == FETCH_RUN);
   assign w_accept    = !w_run && r_load_ready && bus.load_valid_in;
   assign w_count_nxt = r_load_count + CW'(w_accept);
   assign w_load_done = (w_accept && bus.load_last_in) || bus.start_in || (w_count_nxt == CNT_MAX);

   // A redirect issues its target on the same edge that squashes the old fetches,
   // and it wins over a simultaneous stall.
   assign w_issue     = w_run && (bus.redirect_in || !bus.stall_in);
   assign w_issue_pc  = bus.redirect_in
                      ? {bus.redirect_pc_in[XLEN-1:WORD_OFFSET], {WORD_OFFSET{1'b0}}}
                      : r_pc;
   assign w_unused_rpc = ^bus.redirect_pc_in[WORD_OFFSET-1:0];

   assign w_ram_addr  = w_run ? w_issue_pc[AW+WORD_OFFSET-1:WORD_OFFSET] : r_load_count[AW-1:0];
   assign w_ram_en    = w_run ? w_issue : w_accept;
   assign w_ram_we    = !w_run && w_accept;

   fetch_ram #(
      .WIDTH   (XLEN),
      .DEPTH   (IMEM_DEPTH),
      .LATENCY (MEM_LATENCY)
   ) u_ram (
      .clk       (clk_100mhz),
      .rstn      (rst_in),
      .i_en      (w_ram_en),
      .i_we      (w_ram_we),
      .i_addr    (w_ram_addr),
      .i_wdata   (bus.load_data_in),
      .i_oreg_en (w_issue),
      .o_rdata   (w_rdata)
   );

   always_ff @(posedge clk_100mhz) begin
      if (!rst_in) begin
         r_state      <= FETCH_LOAD;
         r_load_ready <= 1'b0;
         r_load_count <= '0;
         r_pc         <= PC_INIT;
         r_stg_vld    <= '0;
         for (int k = 0; k < MEM_LATENCY; k++) begin
            r_stg_pc[k] <= '0;
         end
      end else begin
         case (r_state)
            FETCH_LOAD: begin
               r_load_count <= w_count_nxt;
               if (w_load_done) begin
                  r_state      <= FETCH_RUN;
                  r_load_ready <= 1'b0;
                  r_pc         <= PC_INIT;
               end else begin
                  r_load_ready <= 1'b1;
               end
            end
            FETCH_RUN: begin
               if (w_issue) begin
                  r_pc         <= w_issue_pc + PC_STEP;
                  r_stg_vld[0] <= 1'b1;
                  r_stg_pc[0]  <= w_issue_pc;
                  for (int k = 1; k < MEM_LATENCY; k++) begin
                     r_stg_vld[k] <= r_stg_vld[k-1] && !bus.redirect_in;
                     r_stg_pc[k]  <= r_stg_pc[k-1];
                  end
               end
            end
            default: r_state <= FETCH_LOAD;
         endcase
      end
   end

   assign bus.load_ready_out = r_load_ready;
   assign bus.load_count_out = r_load_count;
   assign bus.running_out    = w_run;
   assign bus.inst_valid_out = r_stg_vld[MEM_LATENCY-1];
   assign bus.pc_out         = r_stg_pc[MEM_LATENCY-1];
   assign bus.inst_out       = w_rdata;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - scoreboard bench for inst_fetch_unit (4096x lat2, 8x lat2, 8x lat1)
module tb_inst_fetch_unit;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        chk;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a;
   logic        rst_bc;
   logic        bc_valid;
   logic [31:0] bc_data;
   int          errors = 0;
   int          checks = 0;
   exp_t        q [3][$];

   inst_fetch_unit_if #(.XLEN(32), .IMEM_DEPTH(4096)) if_a ();
   inst_fetch_unit_if #(.XLEN(32), .IMEM_DEPTH(8))    if_b ();
   inst_fetch_unit_if #(.XLEN(32), .IMEM_DEPTH(8))    if_c ();

   assign if_b.load_valid_in  = bc_valid;
   assign if_b.load_data_in   = bc_data;
   assign if_b.load_last_in   = 1'b0;
   assign if_b.start_in       = 1'b0;
   assign if_b.stall_in       = 1'b0;
   assign if_b.redirect_in    = 1'b0;
   assign if_b.redirect_pc_in = 32'h0;
   assign if_c.load_valid_in  = bc_valid;
   assign if_c.load_data_in   = bc_data;
   assign if_c.load_last_in   = 1'b0;
   assign if_c.start_in       = 1'b0;
   assign if_c.stall_in       = 1'b0;
   assign if_c.redirect_in    = 1'b0;
   assign if_c.redirect_pc_in = 32'h0;

   inst_fetch_unit #(.XLEN(32), .IMEM_DEPTH(4096), .MEM_LATENCY(2), .RESET_PC(0)) u_dut_a (
      .clk_100mhz (clk), .rst_in (rst_a), .bus (if_a.slave));
   inst_fetch_unit #(.XLEN(32), .IMEM_DEPTH(8), .MEM_LATENCY(2), .RESET_PC(0)) u_dut_b (
      .clk_100mhz (clk), .rst_in (rst_bc), .bus (if_b.slave));
   inst_fetch_unit #(.XLEN(32), .IMEM_DEPTH(8), .MEM_LATENCY(1), .RESET_PC(0)) u_dut_c (
      .clk_100mhz (clk), .rst_in (rst_bc), .bus (if_c.slave));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input int id, input logic [31:0] pc, input logic [31:0] inst, input logic c);
      exp_t e;
      e.pc   = pc;
      e.inst = inst;
      e.chk  = c;
      q[id].push_back(e);
   endtask

   task automatic mon(input int id, input logic v, input logic st,
                      input logic [31:0] pc, input logic [31:0] inst);
      exp_t e;
      if (v && !st && q[id].size() > 0) begin
         e = q[id].pop_front();
         chk($sformatf("mon%0d_pc", id), pc, e.pc);
         if (e.chk) chk($sformatf("mon%0d_inst@%0h", id, e.pc), inst, e.inst);
      end
   endtask

   always @(negedge clk) begin
      mon(0, if_a.inst_valid_out, if_a.stall_in, if_a.pc_out, if_a.inst_out);
      mon(1, if_b.inst_valid_out, 1'b0, if_b.pc_out, if_b.inst_out);
      mon(2, if_c.inst_valid_out, 1'b0, if_c.pc_out, if_c.inst_out);
   end

   task automatic drain(input int id);
      int n = 0;
      while (q[id].size() > 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("drain%0d_left", id), q[id].size(), 0);
   endtask

   task automatic send_a(input logic [31:0] d, input logic last);
      int n = 0;
      if_a.load_valid_in = 1'b1;
      if_a.load_data_in  = d;
      if_a.load_last_in  = last;
      @(negedge clk);
      while (!if_a.load_ready_out && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("a_ready", if_a.load_ready_out, 1);
      @(posedge clk); #1;
      if_a.load_valid_in = 1'b0;
      if_a.load_last_in  = 1'b0;
   endtask

   task automatic send_bc(input logic [31:0] d);
      int n = 0;
      bc_valid = 1'b1;
      bc_data  = d;
      @(negedge clk);
      while (!if_b.load_ready_out && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bc_ready", if_b.load_ready_out, 1);
      @(posedge clk); #1;
      bc_valid = 1'b0;
   endtask

   task automatic reset_state_a(input string tag);
      chk({tag, "_ready"}, if_a.load_ready_out, 0);
      chk({tag, "_run"},   if_a.running_out, 0);
      chk({tag, "_valid"}, if_a.inst_valid_out, 0);
      chk({tag, "_inst"},  if_a.inst_out, 0);
      chk({tag, "_pc"},    if_a.pc_out, 0);
      chk({tag, "_cnt"},   32'(if_a.load_count_out), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_a = 1'b0;
      rst_bc = 1'b0;
      bc_valid = 1'b0;
      bc_data = 32'h0;
      if_a.load_valid_in = 1'b0;
      if_a.load_data_in = 32'h0;
      if_a.load_last_in = 1'b0;
      if_a.start_in = 1'b0;
      if_a.stall_in = 1'b0;
      if_a.redirect_in = 1'b0;
      if_a.redirect_pc_in = 32'h0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_state_a("rst0");

      // Load 0xA,0xB,0xC with last on 0xC, then fetch starts from pc 0.
      push(0, 32'h0, 32'hA, 1'b1);
      push(0, 32'h4, 32'hB, 1'b1);
      push(0, 32'h8, 32'hC, 1'b1);
      @(posedge clk); #1;
      rst_a = 1'b1;
      send_a(32'hA, 1'b0);
      send_a(32'hB, 1'b0);
      send_a(32'hC, 1'b1);
      @(negedge clk);
      chk("a_cnt", 32'(if_a.load_count_out), 3);
      chk("a_run", if_a.running_out, 1);
      chk("a_lat_c0", if_a.inst_valid_out, 0);
      @(negedge clk);
      chk("a_lat_c1", if_a.inst_valid_out, 0);
      @(negedge clk);
      chk("a_lat_c2", if_a.inst_valid_out, 1);

      // Stall for three cycles while pc 4 is at the output.
      @(posedge clk); #1;
      if_a.stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_pc", i), if_a.pc_out, 32'h4);
         chk($sformatf("stall%0d_inst", i), if_a.inst_out, 32'hB);
         chk($sformatf("stall%0d_v", i), if_a.inst_valid_out, 1);
         if (i < 2) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      if_a.stall_in = 1'b0;
      drain(0);

      // Redirect together with stall: flush wins and pc 0 is refetched.
      @(posedge clk); #1;
      if_a.redirect_in = 1'b1;
      if_a.redirect_pc_in = 32'h0;
      if_a.stall_in = 1'b1;
      push(0, 32'h0, 32'hA, 1'b1);
      @(posedge clk); #1;
      if_a.redirect_in = 1'b0;
      if_a.stall_in = 1'b0;
      @(negedge clk);
      chk("rs_flush_v", if_a.inst_valid_out, 0);

      // Redirect to 0x11 while pcs 4 and 8 are in flight.
      @(posedge clk); #1;
      if_a.redirect_in = 1'b1;
      if_a.redirect_pc_in = 32'h11;
      push(0, 32'h10, 32'h0, 1'b0);
      push(0, 32'h14, 32'h0, 1'b0);
      push(0, 32'h18, 32'h0, 1'b0);
      @(posedge clk); #1;
      if_a.redirect_in = 1'b0;
      @(negedge clk);
      chk("rd_bubble_v", if_a.inst_valid_out, 0);
      @(negedge clk);
      chk("rd_lat_v", if_a.inst_valid_out, 1);
      chk("rd_lat_pc", if_a.pc_out, 32'h10);
      drain(0);

      // Reset mid-RUN with a load beat and start held through the reset.
      @(posedge clk); #1;
      rst_a = 1'b0;
      if_a.load_valid_in = 1'b1;
      if_a.load_data_in = 32'hDEAD;
      if_a.start_in = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      reset_state_a("rst1");
      push(0, 32'h0, 32'hA, 1'b1);
      push(0, 32'h4, 32'hB, 1'b1);
      push(0, 32'h8, 32'hC, 1'b1);
      @(posedge clk); #1;
      rst_a = 1'b1;
      @(posedge clk); #1;
      if_a.load_valid_in = 1'b0;
      if_a.start_in = 1'b0;
      @(negedge clk);
      chk("rr_run", if_a.running_out, 1);
      chk("rr_cnt", 32'(if_a.load_count_out), 0);
      drain(0);

      // Depth-8 units: eight words without last, auto-RUN, pc wrap onto word 0.
      for (int i = 0; i < 10; i++) begin
         push(1, 32'(i * 4), 32'h100 + 32'(i % 8), 1'b1);
         push(2, 32'(i * 4), 32'h100 + 32'(i % 8), 1'b1);
      end
      @(posedge clk); #1;
      rst_bc = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send_bc(32'h100 + 32'(i));
      end
      @(negedge clk);
      chk("b_cnt", 32'(if_b.load_count_out), 8);
      chk("b_run", if_b.running_out, 1);
      chk("c_run", if_c.running_out, 1);
      chk("b_lat_c0", if_b.inst_valid_out, 0);
      chk("c_lat_c0", if_c.inst_valid_out, 0);
      @(negedge clk);
      chk("b_lat_c1", if_b.inst_valid_out, 0);
      chk("c_lat_c1", if_c.inst_valid_out, 1);
      @(negedge clk);
      chk("b_lat_c2", if_b.inst_valid_out, 1);
      drain(1);
      drain(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
